// File: rtl/bram_word_loader.sv
// ---------------------------------------------------------------------------
// bram_word_loader
//
// Purpose: collects a byte stream into WIDTH-bit words and writes WORDS of
// them into a downstream BRAM wrapper at consecutive word addresses
// 0..WORDS-1. Each write is a single-cycle request, after which the loader
// waits for the wrapper's completion strobe. Then it collects the next word.
//
// Ports:
//   clk_in           - sole clock, rising edge
//   rst_in           - synchronous active-high reset
//   start_in         - begin a load session (honoured only when idle)
//   byte_in          - streamed data byte
//   byte_valid_in    - byte_in is valid
//   byte_ready_out   - loader accepts a byte this cycle
//   addr_out         - word address to the wrapper
//   data_out         - assembled word to the wrapper
//   write_enable_out - single-cycle write request to the wrapper
//   finished_in      - wrapper reports the write is complete
//   busy_out         - session in progress
//   done_out         - one-cycle pulse at session end
// ---------------------------------------------------------------------------
module bram_word_loader #(
    parameter int ADDRS = 24,
    parameter int WIDTH = 256,
    parameter int WORDS = 24
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      start_in,
    input  logic [7:0]                                byte_in,
    input  logic                                      byte_valid_in,
    output logic                                      byte_ready_out,
    output logic [((ADDRS > 1) ? $clog2(ADDRS) : 1)-1:0] addr_out,
    output logic [WIDTH-1:0]                          data_out,
    output logic                                      write_enable_out,
    input  logic                                      finished_in,
    output logic                                      busy_out,
    output logic                                      done_out
);

    localparam int BYTES = WIDTH / 8;
    localparam int AW    = (ADDRS > 1) ? $clog2(ADDRS) : 1;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [BCW-1:0]  r_byte_cnt;
    logic [AW-1:0]   r_word_cnt;
    logic [AW-1:0]   r_addr;

    logic            w_start;
    logic            w_byte_fire;
    logic            w_last_byte;
    logic            w_last_word;
    logic            w_word_done;

    assign w_start     = (r_state == S_IDLE) && start_in;
    assign w_byte_fire = (r_state == S_COLLECT) && byte_valid_in;
    assign w_last_byte = (r_byte_cnt == BCW'(BYTES - 1));
    assign w_last_word = (r_word_cnt == AW'(WORDS - 1));
    // Completion strobe only counts while waiting; anywhere else it is noise.
    assign w_word_done = (r_state == S_WAIT) && finished_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        byte_ready_out   = 1'b0;
        write_enable_out = 1'b0;
        done_out         = 1'b0;
        busy_out         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready_out = 1'b1;
                if (byte_valid_in && w_last_byte) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                write_enable_out = 1'b1;
                w_state_next     = S_WAIT;
            end
            S_WAIT: begin
                if (finished_in) begin
                    w_state_next = w_last_word ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                done_out     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte, word and address counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
        end else if (w_start) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
        end else if (w_byte_fire) begin
            r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
        end else if (w_word_done && !w_last_word) begin
            // Last word stays on its address: no wrap inside a session.
            r_byte_cnt <= '0;
            r_word_cnt <= r_word_cnt + 1'b1;
            r_addr     <= r_addr + 1'b1;
        end
    end

    assign addr_out = r_addr;

    // ------------------------------------------------------------------
    // Byte lanes: the k-th byte of a word lands in bits [8k+7:8k]. Lanes only
    // load in COLLECT, so the word is frozen through WRITE and WAIT.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] r_lane;
            always_ff @(posedge clk_in) begin
                if (rst_in || w_start) begin
                    r_lane <= '0;
                end else if (w_byte_fire && (r_byte_cnt == BCW'(gi))) begin
                    r_lane <= byte_in;
                end
            end
            assign data_out[gi*8 +: 8] = r_lane;
        end
    endgenerate

endmodule

// File: tb/tb_bram_word_loader.sv
// ---------------------------------------------------------------------------
// tb_bram_word_loader
//
// Two loader instances share every input: one loads a single word per
// session, the other loads the full 24 words. A negedge monitor logs every
// write pulse and done pulse of both instances.
// ---------------------------------------------------------------------------
module tb_bram_word_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   bdata;
    logic         bvalid;
    logic         finished;

    logic         rdy1, we1, busy1, done1;
    logic [4:0]   addr1;
    logic [255:0] data1;
    logic         rdy24, we24, busy24, done24;
    logic [4:0]   addr24;
    logic [255:0] data24;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_word_loader #(.ADDRS(24), .WIDTH(256), .WORDS(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .byte_in(bdata),
        .byte_valid_in(bvalid), .byte_ready_out(rdy1), .addr_out(addr1),
        .data_out(data1), .write_enable_out(we1), .finished_in(finished),
        .busy_out(busy1), .done_out(done1)
    );

    bram_word_loader #(.ADDRS(24), .WIDTH(256), .WORDS(24)) dut24 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .byte_in(bdata),
        .byte_valid_in(bvalid), .byte_ready_out(rdy24), .addr_out(addr24),
        .data_out(data24), .write_enable_out(we24), .finished_in(finished),
        .busy_out(busy24), .done_out(done24)
    );

    // Write / done monitor, sampled away from the active edge.
    int           we_cnt1 = 0, done_cnt1 = 0, we_cnt24 = 0, done_cnt24 = 0;
    logic [4:0]   wa[128];
    logic [255:0] wd[128];

    always @(negedge clk) begin
        if (we1) we_cnt1++;
        if (done1) done_cnt1++;
        if (done24) done_cnt24++;
        if (we24) begin
            if (we_cnt24 < 128) begin
                wa[we_cnt24] = addr24;
                wd[we_cnt24] = data24;
            end
            we_cnt24++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; bvalid = 1'b0; finished = 1'b0; bdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Stream bytes lo..hi of w into the 24-word instance.
    task automatic send_bytes(input logic [255:0] w, input int lo, input int hi);
        int budget;
        for (int k = lo; k <= hi; k++) begin
            bdata  = w[k*8 +: 8];
            bvalid = 1'b1;
            budget = 0;
            while (!rdy24 && budget < 20) begin
                tick();
                budget++;
            end
            if (budget >= 20) begin
                checks++;
                failures++;
                $display("FAIL send_timeout byte=%0d ready=%0b required=1", k, rdy24);
            end
            tick();
        end
        bvalid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        pulse_start();
        send_bytes(256'h0000000000000000000000000000000000000000000000000000000000C3B2A1, 0, 2);
        rst = 1'b1; bvalid = 1'b1;
        tick();
        tick();
        checks++;
        if ({rdy24, we24, busy24, done24} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl24 got=%b required=0000", {rdy24, we24, busy24, done24});
        end
        checks++;
        if ({rdy1, we1, busy1, done1} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl1 got=%b required=0000", {rdy1, we1, busy1, done1});
        end
        checks++;
        if (addr24 !== 5'd0 || data24 !== 256'd0) begin
            failures++;
            $display("FAIL reset_addr_data got addr=%0d data=%h required 0/0", addr24, data24);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rdy24 !== 1'b0 || busy24 !== 1'b0) begin
                failures++;
                $display("FAIL idle_ignores_valid cyc=%0d ready=%b busy=%b required 0/0", i, rdy24, busy24);
            end
        end
        bvalid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_word();
        logic [255:0] exp_w;
        int b_we1, b_done1;
        exp_w = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
        do_reset();
        b_we1 = we_cnt1; b_done1 = done_cnt1;
        pulse_start();
        checks++;
        if (rdy1 !== 1'b1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL start_to_collect ready=%b busy=%b required 1/1", rdy1, busy1);
        end
        send_bytes(exp_w, 0, 31);
        checks++;
        if (we1 !== 1'b1 || addr1 !== 5'd0 || data1 !== exp_w) begin
            failures++;
            $display("FAIL single_write we=%b addr=%0d data=%h required 1/0/%h", we1, addr1, data1, exp_w);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (we1 !== 1'b0 || rdy1 !== 1'b0 || data1 !== exp_w) begin
                failures++;
                $display("FAIL single_wait cyc=%0d we=%b ready=%b data=%h", i, we1, rdy1, data1);
            end
            tick();
        end
        finished = 1'b1;
        tick();
        finished = 1'b0;
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL single_done done=%b busy=%b required 1/1", done1, busy1);
        end
        checks++;
        if (addr24 !== 5'd1 || rdy24 !== 1'b1) begin
            failures++;
            $display("FAIL next_word24 addr=%0d ready=%b required 1/1", addr24, rdy24);
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL single_idle done=%b busy=%b required 0/0", done1, busy1);
        end
        checks++;
        if (we_cnt1 - b_we1 !== 1 || done_cnt1 - b_done1 !== 1) begin
            failures++;
            $display("FAIL single_counts writes=%0d dones=%0d required 1/1", we_cnt1 - b_we1, done_cnt1 - b_done1);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic [255:0] pa, pb;
        int base;
        pa = rand_word();
        pb = rand_word();
        pb[7:0] = 8'h55;
        do_reset();
        base = we_cnt24;
        pulse_start();
        send_bytes(pa, 0, 31);
        bvalid = 1'b1; bdata = 8'hAA;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rdy24 !== 1'b0 || data24 !== pa) begin
                failures++;
                $display("FAIL wait_backpressure cyc=%0d ready=%b data=%h required 0/%h", i, rdy24, data24, pa);
            end
            tick();
        end
        finished = 1'b1;
        tick();
        finished = 1'b0;
        send_bytes(pb, 0, 31);
        checks++;
        if (we24 !== 1'b1 || addr24 !== 5'd1 || data24 !== pb) begin
            failures++;
            $display("FAIL word1_after_wait we=%b addr=%0d data=%h required 1/1/%h", we24, addr24, data24, pb);
        end
        tick();
        checks++;
        if (we_cnt24 - base !== 2 || wa[base] !== 5'd0 || wd[base] !== pa) begin
            failures++;
            $display("FAIL word0_log writes=%0d addr=%0d required 2/0", we_cnt24 - base, wa[base]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_session();
        logic [255:0] sb[24];
        int base, dbase;
        do_reset();
        base = we_cnt24; dbase = done_cnt24;
        pulse_start();
        for (int w = 0; w < 24; w++) begin
            sb[w] = rand_word();
            send_bytes(sb[w], 0, 31);
            tick();
            repeat (w % 3) tick();
            finished = 1'b1;
            tick();
            finished = 1'b0;
        end
        tick();
        checks++;
        if (we_cnt24 - base !== 24 || done_cnt24 - dbase !== 1) begin
            failures++;
            $display("FAIL full_counts writes=%0d dones=%0d required 24/1", we_cnt24 - base, done_cnt24 - dbase);
        end
        for (int w = 0; w < 24; w++) begin
            checks++;
            if (wa[base + w] !== 5'(w) || wd[base + w] !== sb[w]) begin
                failures++;
                $display("FAIL full_word%0d addr=%0d data=%h required %0d/%h", w, wa[base + w], wd[base + w], w, sb[w]);
            end
        end
        checks++;
        if (busy24 !== 1'b0 || addr24 > 5'd23) begin
            failures++;
            $display("FAIL full_end busy=%b addr=%0d required 0/<=23", busy24, addr24);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midword();
        logic [255:0] pc, pd;
        int base;
        pc = rand_word();
        pd = rand_word();
        do_reset();
        base = we_cnt24;
        pulse_start();
        send_bytes(pc, 0, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy24 !== 1'b0 || addr24 !== 5'd0 || data24 !== 256'd0 || we_cnt24 != base) begin
            failures++;
            $display("FAIL midword_reset busy=%b addr=%0d writes=%0d required 0/0/0", busy24, addr24, we_cnt24 - base);
        end
        pulse_start();
        send_bytes(pd, 0, 31);
        checks++;
        if (we24 !== 1'b1 || addr24 !== 5'd0 || data24 !== pd) begin
            failures++;
            $display("FAIL restart_write we=%b addr=%0d data=%h required 1/0/%h", we24, addr24, data24, pd);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_start_ignored();
        logic [255:0] pe, pf;
        int dbase;
        pe = rand_word();
        pf = rand_word();
        do_reset();
        dbase = done_cnt24;
        pulse_start();
        send_bytes(pe, 0, 4);
        pulse_start();
        checks++;
        if (rdy24 !== 1'b1 || addr24 !== 5'd0) begin
            failures++;
            $display("FAIL start_in_collect ready=%b addr=%0d required 1/0", rdy24, addr24);
        end
        send_bytes(pe, 5, 31);
        checks++;
        if (we24 !== 1'b1 || data24 !== pe) begin
            failures++;
            $display("FAIL start_keeps_bytes we=%b data=%h required 1/%h", we24, data24, pe);
        end
        // finished_in during WRITE must not skip the wait.
        finished = 1'b1; start = 1'b1;
        tick();
        finished = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (we24 !== 1'b0 || rdy24 !== 1'b0 || busy24 !== 1'b1 || addr24 !== 5'd0) begin
            failures++;
            $display("FAIL still_waiting we=%b ready=%b busy=%b addr=%0d required 0/0/1/0", we24, rdy24, busy24, addr24);
        end
        pulse_start();
        checks++;
        if (rdy24 !== 1'b0 || addr24 !== 5'd0) begin
            failures++;
            $display("FAIL start_in_wait ready=%b addr=%0d required 0/0", rdy24, addr24);
        end
        finished = 1'b1;
        tick();
        finished = 1'b0;
        checks++;
        if (rdy24 !== 1'b1 || addr24 !== 5'd1) begin
            failures++;
            $display("FAIL advance_after_wait ready=%b addr=%0d required 1/1", rdy24, addr24);
        end
        send_bytes(pf, 0, 31);
        checks++;
        if (we24 !== 1'b1 || addr24 !== 5'd1 || data24 !== pf || done_cnt24 != dbase) begin
            failures++;
            $display("FAIL word1_write we=%b addr=%0d data=%h dones=%0d required 1/1/%h/0", we24, addr24, data24, done_cnt24 - dbase, pf);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bdata = 8'h00; bvalid = 1'b0; finished = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_full_session();
        test_reset_midword();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
